// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, imem req/ack with one-entry skid, IF/ID register.
// Optional macro IF_PERF_CNT_EN adds saturating stall/flush cycle counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h80000000,
  parameter logic [31:0] INT_VECTOR = 32'h80000004,
  parameter logic [31:0] EXC_VECTOR = 32'h80000008,
  parameter logic [31:0] NOP_INST   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  PCSrc,
  input  logic        BranchHazard,
  input  logic        JumpHazard,
  input  logic        DataHazard,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_instruction,
  output logic [31:0] IF_ID_PC_plus_4,
  output logic [31:0] PC_Interrupt
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_DROP, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_run;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_drop_addr, w_drop_addr_nxt;
  logic [31:0] r_skid, w_skid_nxt;
  logic [31:0] r_ifid_inst, w_ifid_inst_nxt;
  logic [31:0] r_ifid_pc4, w_ifid_pc4_nxt;
  logic [31:0] w_target_raw, w_target, w_pc_plus4;
  logic        w_redirect, w_req, w_ack;

  assign w_redirect = ~DataHazard & (BranchHazard | JumpHazard |
                                     (PCSrc == 3'b100) | (PCSrc == 3'b101));
  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    case (PCSrc)
      3'b001:  w_target_raw = branch_target;
      3'b010:  w_target_raw = jump_target;
      3'b011:  w_target_raw = jr_target;
      3'b100:  w_target_raw = INT_VECTOR;
      3'b101:  w_target_raw = EXC_VECTOR;
      default: w_target_raw = w_pc_plus4;
    endcase
  end
  assign w_target = {w_target_raw[31:2], 2'b00};

  // r_run holds the request low during the reset cycle and restarts fetch right after it
  assign w_req     = r_run & (r_state != S_HOLD);
  assign w_ack     = w_req & imem_ack;
  assign imem_req  = w_req;
  assign imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_drop_addr_nxt = r_drop_addr;
    w_skid_nxt      = r_skid;
    w_ifid_inst_nxt = NOP_INST;
    w_ifid_pc4_nxt  = w_pc_plus4;
    case (r_state)
      S_FETCH: begin
        if (w_ack) begin
          if (DataHazard) begin
            w_skid_nxt  = imem_rdata;
            w_state_nxt = S_HOLD;
          end else if (w_redirect) begin
            w_pc_nxt = w_target;
          end else begin
            w_ifid_inst_nxt = imem_rdata;
            w_pc_nxt        = w_pc_plus4;
          end
        end else if (w_redirect) begin
          w_pc_nxt = w_target;
          if (r_run) begin
            w_drop_addr_nxt = r_pc;
            w_state_nxt     = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (w_redirect) w_pc_nxt = w_target;
        if (w_ack) w_state_nxt = S_FETCH;
      end
      S_HOLD: begin
        if (!DataHazard) begin
          w_state_nxt = S_FETCH;
          if (w_redirect) begin
            w_pc_nxt = w_target;
          end else begin
            w_ifid_inst_nxt = r_skid;
            w_pc_nxt        = w_pc_plus4;
          end
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
    // A load-use stall freezes IF/ID; a redirect flushes it to a bubble tagged with the target
    if (DataHazard) begin
      w_ifid_inst_nxt = r_ifid_inst;
      w_ifid_pc4_nxt  = r_ifid_pc4;
    end else if (w_redirect) begin
      w_ifid_inst_nxt = NOP_INST;
      w_ifid_pc4_nxt  = w_target + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_run       <= 1'b0;
      r_pc        <= RESET_PC;
      r_drop_addr <= RESET_PC;
      r_skid      <= NOP_INST;
      r_ifid_inst <= NOP_INST;
      r_ifid_pc4  <= RESET_PC + 32'd4;
    end else begin
      r_state     <= w_state_nxt;
      r_run       <= 1'b1;
      r_pc        <= w_pc_nxt;
      r_drop_addr <= w_drop_addr_nxt;
      r_skid      <= w_skid_nxt;
      r_ifid_inst <= w_ifid_inst_nxt;
      r_ifid_pc4  <= w_ifid_pc4_nxt;
    end
  end

  assign IF_ID_instruction = r_ifid_inst;
  assign IF_ID_PC_plus_4   = r_ifid_pc4;
  assign PC_Interrupt      = r_ifid_pc4 - 32'd4;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (DataHazard && (r_stall_cnt != 32'hFFFFFFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_redirect && (r_flush_cnt != 32'hFFFFFFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`else
  // counters not built
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a switchable zero-wait echo memory and hand-driven responses.
module tb_if_fetch_stage;

  logic        clk, rst_n;
  logic [2:0]  PCSrc;
  logic        BranchHazard, JumpHazard, DataHazard;
  logic [31:0] branch_target, jump_target, jr_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IF_ID_instruction, IF_ID_PC_plus_4, PC_Interrupt;

  logic        zw;
  logic        man_ack;
  logic [31:0] man_rdata;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .PCSrc             (PCSrc),
    .BranchHazard      (BranchHazard),
    .JumpHazard        (JumpHazard),
    .DataHazard        (DataHazard),
    .branch_target     (branch_target),
    .jump_target       (jump_target),
    .jr_target         (jr_target),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ack          (imem_ack),
    .imem_rdata        (imem_rdata),
    .IF_ID_instruction (IF_ID_instruction),
    .IF_ID_PC_plus_4   (IF_ID_PC_plus_4),
    .PC_Interrupt      (PC_Interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (zw) begin
      imem_ack   = imem_req;
      imem_rdata = imem_addr;
    end else begin
      imem_ack   = man_ack;
      imem_rdata = man_rdata;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_hz();
    PCSrc = 3'b000; BranchHazard = 1'b0; JumpHazard = 1'b0; DataHazard = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; zw = 1'b1; man_ack = 1'b0; man_rdata = 32'h0;
    clr_hz();
    branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_req", {31'd0, imem_req}, 32'd0);
    chk_eq("rst_inst", IF_ID_instruction, 32'h00000000);
    chk_eq("rst_pc4", IF_ID_PC_plus_4, 32'h80000004);
    chk_eq("rst_pcint", PC_Interrupt, 32'h80000000);

    // 1: zero-wait streaming
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk_eq("t1_req", {31'd0, imem_req}, 32'd1);
    chk_eq("t1_addr0", imem_addr, 32'h80000000);
    tick();
    chk_eq("t1_inst0", IF_ID_instruction, 32'h80000000);
    chk_eq("t1_pc4_0", IF_ID_PC_plus_4, 32'h80000004);
    tick();
    chk_eq("t1_inst1", IF_ID_instruction, 32'h80000004);
    chk_eq("t1_pc4_1", IF_ID_PC_plus_4, 32'h80000008);
    tick();
    chk_eq("t1_inst2", IF_ID_instruction, 32'h80000008);
    chk_eq("t1_pc4_2", IF_ID_PC_plus_4, 32'h8000000C);

    // 2: ack during a load-use stall goes to the skid
    zw = 1'b0; man_ack = 1'b1; man_rdata = 32'h8C220000; DataHazard = 1'b1;
    tick();
    chk_eq("t2_hold_inst0", IF_ID_instruction, 32'h80000008);
    man_ack = 1'b0;
    chk_eq("t2_noreq0", {31'd0, imem_req}, 32'd0);
    tick();
    chk_eq("t2_hold_inst1", IF_ID_instruction, 32'h80000008);
    chk_eq("t2_hold_pc4", IF_ID_PC_plus_4, 32'h8000000C);
    chk_eq("t2_noreq1", {31'd0, imem_req}, 32'd0);
    DataHazard = 1'b0;
    tick();
    chk_eq("t2_skid_inst", IF_ID_instruction, 32'h8C220000);
    chk_eq("t2_skid_pc4", IF_ID_PC_plus_4, 32'h80000010);
    chk_eq("t2_req", {31'd0, imem_req}, 32'd1);
    chk_eq("t2_addr", imem_addr, 32'h80000010);

    // 3: branch during an outstanding 3-cycle fetch
    tick();
    BranchHazard = 1'b1; PCSrc = 3'b001; branch_target = 32'h00400100;
    tick();
    chk_eq("t3_flush_inst", IF_ID_instruction, 32'h00000000);
    chk_eq("t3_flush_pc4", IF_ID_PC_plus_4, 32'h00400104);
    clr_hz();
    chk_eq("t3_drop_req", {31'd0, imem_req}, 32'd1);
    chk_eq("t3_drop_addr", imem_addr, 32'h80000010);
    tick();
    man_ack = 1'b1; man_rdata = 32'hDEADBEEF;
    tick();
    man_ack = 1'b0;
    chk_eq("t3_discard", IF_ID_instruction, 32'h00000000);
    chk_eq("t3_new_addr", imem_addr, 32'h00400100);

    // 5: redirect with ack in the same cycle, then an unaligned jr into DROP
    man_ack = 1'b1; man_rdata = 32'h11111111;
    JumpHazard = 1'b1; PCSrc = 3'b010; jump_target = 32'h00400200;
    tick();
    chk_eq("t5_inst", IF_ID_instruction, 32'h00000000);
    chk_eq("t5_pc4", IF_ID_PC_plus_4, 32'h00400204);
    clr_hz(); man_ack = 1'b0;
    chk_eq("t5_addr", imem_addr, 32'h00400200);
    JumpHazard = 1'b1; PCSrc = 3'b011; jr_target = 32'h00400333;
    tick();
    chk_eq("t5_jr_pc4", IF_ID_PC_plus_4, 32'h00400334);
    clr_hz(); man_ack = 1'b1; man_rdata = 32'h0;
    chk_eq("t5_jr_drop_addr", imem_addr, 32'h00400200);
    tick();
    man_ack = 1'b0;
    chk_eq("t5_jr_addr", imem_addr, 32'h00400330);

    // 4: interrupt, interrupt masked by stall, exception, reserved PCSrc
    man_ack = 1'b1; man_rdata = 32'h22222222; PCSrc = 3'b100;
    tick();
    chk_eq("t4_int_inst", IF_ID_instruction, 32'h00000000);
    chk_eq("t4_int_pc4", IF_ID_PC_plus_4, 32'h80000008);
    man_ack = 1'b0; DataHazard = 1'b1;
    tick();
    chk_eq("t4_stall_pc4", IF_ID_PC_plus_4, 32'h80000008);
    chk_eq("t4_stall_addr", imem_addr, 32'h80000004);
    DataHazard = 1'b0; PCSrc = 3'b101; man_ack = 1'b1;
    tick();
    chk_eq("t4_exc_pc4", IF_ID_PC_plus_4, 32'h8000000C);
    chk_eq("t4_exc_addr", imem_addr, 32'h80000008);
    PCSrc = 3'b110; man_rdata = 32'hABCD0000;
    tick();
    chk_eq("t4_rsv_inst", IF_ID_instruction, 32'hABCD0000);
    chk_eq("t4_rsv_pc4", IF_ID_PC_plus_4, 32'h8000000C);
    chk_eq("t4_rsv_addr", imem_addr, 32'h8000000C);

    // PC+4 wraps at the top of the address space
    JumpHazard = 1'b1; PCSrc = 3'b011; jr_target = 32'hFFFFFFFF;
    tick();
    chk_eq("wr_pc4", IF_ID_PC_plus_4, 32'h00000000);
    chk_eq("wr_pcint", PC_Interrupt, 32'hFFFFFFFC);
    chk_eq("wr_addr", imem_addr, 32'hFFFFFFFC);
    clr_hz(); man_rdata = 32'h12345678;
    tick();
    chk_eq("wr_inst", IF_ID_instruction, 32'h12345678);
    chk_eq("wr_next_addr", imem_addr, 32'h00000000);

    // 6: asynchronous reset in the middle of a request
    JumpHazard = 1'b1; PCSrc = 3'b010; jump_target = 32'h00400020;
    tick();
    clr_hz(); man_ack = 1'b0;
    chk_eq("t6_addr", imem_addr, 32'h00400020);
    chk_eq("t6_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("t6_rst_req", {31'd0, imem_req}, 32'd0);
    chk_eq("t6_rst_inst", IF_ID_instruction, 32'h00000000);
    chk_eq("t6_rst_pc4", IF_ID_PC_plus_4, 32'h80000004);
    chk_eq("t6_rst_pcint", PC_Interrupt, 32'h80000000);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk_eq("t6_restart_req", {31'd0, imem_req}, 32'd1);
    chk_eq("t6_restart_addr", imem_addr, 32'h80000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; the upstream end of the IF/ID interface that the decode stage consumes.
- Owns the PC register and next-PC selection from decode's PCSrc, branch, jump and jr targets.
- Runs a req/ack handshake to instruction memory, with a 1-entry skid buffer for fetches that return during a stall.
- Drives the IF/ID pipeline register and PC_Interrupt, the return address used by decode on IRQ/exception.

Parameters:
RESET_PC  32'h80000000  PC after reset; kernel space, so the supervise bit is set.
INT_VECTOR  32'h80000004  interrupt handler entry.
EXC_VECTOR  32'h80000008  exception handler entry.
NOP_INST  32'h00000000  bubble instruction.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
PCSrc  in  3  from decode: 000 PC+4, 001 branch, 010 jump, 011 jr, 100 interrupt, 101 exception; 110/111 treated as 000.
BranchHazard  in  1  branch taken in ID.
JumpHazard  in  1  j/jal/jr/jalr in ID.
DataHazard  in  1  load-use stall: hold PC and IF/ID.
branch_target  in  32  branch address.
jump_target  in  32  j/jal address.
jr_target  in  32  jr/jalr address.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ack=0.
imem_ack  in  1  data valid on imem_rdata this cycle.
imem_rdata  in  32  fetched word.
IF_ID_instruction  out  32  instruction to decode.
IF_ID_PC_plus_4  out  32  PC+4 of that instruction.
PC_Interrupt  out  32  IF_ID_PC_plus_4 - 4.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC, state=FETCH, skid empty, imem_req=0.
  - IF_ID_instruction=NOP_INST, IF_ID_PC_plus_4=RESET_PC+4.
  - imem_req rises in the first cycle after rst_n deasserts.
- redirect = ~DataHazard & (BranchHazard | JumpHazard | PCSrc==100 | PCSrc==101). DataHazard beats redirect because decode re-evaluates the branch next cycle.
- Redirect target by PCSrc:
  - 001: branch_target
  - 010: jump_target
  - 011: jr_target
  - 100: INT_VECTOR
  - 101: EXC_VECTOR
- States:
  - FETCH: imem_req=1, imem_addr=PC. On ack:
    - no stall and no redirect: word goes to IF/ID, PC+=4, stay in FETCH.
    - DataHazard: word goes to skid, go to HOLD.
    - redirect: word discarded, PC=target, stay in FETCH.
    - No ack and redirect: PC=target, go to DROP.
  - DROP: imem_req=1 with the old address latched, until ack. Ack data discarded, then go to FETCH. A further redirect in DROP updates PC only.
  - HOLD: imem_req=0. When DataHazard falls: skid goes to IF/ID, PC+=4, go to FETCH. Redirect in HOLD: skid invalidated, PC=target, go to FETCH.
- IF/ID update, each cycle:
  - DataHazard=1: hold both registers.
  - redirect=1: flush to NOP_INST; IF_ID_PC_plus_4 = target+4.
  - new word delivered: load word and its fetch PC+4.
  - otherwise: bubble, NOP_INST with PC+4, so the supervise bit stays valid on bubbles.
- Latency: fetch response at cycle N appears on IF_ID_instruction at N+1. Zero-wait memory (ack same cycle as req) sustains 1 instruction/cycle.
- Arithmetic: 32-bit, PC+4 wraps mod 2^32. PC[1:0] forced to 00 on every load.
- Reset mid-fetch: request abandoned immediately; memory must tolerate req dropping without ack.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - adds outputs perf_stall_cnt[31:0] (cycles with DataHazard=1) and perf_flush_cnt[31:0] (cycles with redirect=1).
  - both counters reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: the ports are absent and no counter logic exists.

Test Plan:
1. Zero-wait memory returns rdata=addr, no hazards, after reset → IF/ID sequence 80000000, 80000004, 80000008 with PC_plus_4 +4 each, one per cycle.
2. DataHazard for 2 cycles while ack arrives with 0x8C220000 → IF/ID held 2 cycles; 0x8C220000 delivered the cycle after DataHazard falls, no extra imem_req during HOLD.
3. 3-cycle memory latency; at cycle 1 of the fetch BranchHazard=1, PCSrc=001, branch_target=0x00400100 → old fetch data discarded, next imem_addr=0x00400100, IF/ID=NOP with PC_plus_4=0x00400104.
4. PCSrc=100 with DataHazard=0 → PC=0x80000004, IF/ID flushed; PCSrc=100 with DataHazard=1 → ignored, PC and IF/ID unchanged.
5. Redirect and ack in the same cycle → rdata dropped, no DROP state, imem_addr=target next cycle.
6. rst_n pulsed low mid-request at PC=0x00400020 → outputs at reset values immediately, fetch restarts at 0x80000000.
